// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the decode stage: control bundle, opcode and
// funct fields, ALU operation codes (including M extension) and skid states.
package decode_stage_pkg;

  // Major opcodes
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  // funct3 values that need special handling
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Sr     = 3'b101;

  // funct7 values
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  typedef enum logic [4:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd,
    AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu
  } alu_op_e;

  typedef enum logic [1:0] {SrcaReg, SrcaPc, SrcaZero} alu_srca_e;
  typedef enum logic [0:0] {SrcbReg, SrcbImm} alu_srcb_e;
  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;
  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4} wb_sel_e;
  typedef enum logic [3:0] {
    BjNoop, BjBeq, BjBne, BjBlt, BjBge, BjBltu, BjBgeu, BjJal, BjJalr
  } bj_op_e;

  // All-zero value is the "nothing happens" bundle used for illegal entries
  typedef struct packed {
    alu_op_e   alu_op;
    alu_srca_e alu_srca;
    alu_srcb_e alu_srcb;
    imm_sel_e  imm_sel;
    logic      reg_we;
    wb_sel_e   wb_sel;
    logic      mem_d_re;
    logic      mem_d_we;
    logic [2:0] mem_size;
    bj_op_e    bj_op;
  } controlsgs_t;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} skid_state_e;

  // Base integer ALU op from funct3; alt selects SUB/SRA
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  // M-extension ALU op from funct3
  function automatic alu_op_e alu_muldiv(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = AluMul;
      3'b001:  op = AluMulh;
      3'b010:  op = AluMulhsu;
      3'b011:  op = AluMulhu;
      3'b100:  op = AluDiv;
      3'b101:  op = AluDivu;
      3'b110:  op = AluRem;
      default: op = AluRemu;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_core.sv
// Combinational RV32I(M) decoder: raw instruction word to control bundle plus
// an illegal flag. Illegal words always produce the all-zero bundle.
module decode_core
  import decode_stage_pkg::*;
#(
  parameter bit RV32M  = 1'b0,
  parameter bit STRICT = 1'b1
) (
  input  logic [31:0]  instr,
  output controlsgs_t  ctrl,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  // Register indices and immediates are extracted downstream from out_instr
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Decode opcode/funct fields into control signals and legality
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    if (opcode[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OpcLui: begin
          ctrl.alu_srca = SrcaZero;
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmU;
          ctrl.reg_we   = 1'b1;
        end
        OpcAuipc: begin
          ctrl.alu_srca = SrcaPc;
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmU;
          ctrl.reg_we   = 1'b1;
        end
        OpcJal: begin
          ctrl.alu_srca = SrcaPc;
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmJ;
          ctrl.reg_we   = 1'b1;
          ctrl.wb_sel   = WbPc4;
          ctrl.bj_op    = BjJal;
        end
        OpcJalr: begin
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmI;
          ctrl.reg_we   = 1'b1;
          ctrl.wb_sel   = WbPc4;
          ctrl.bj_op    = BjJalr;
        end
        OpcBranch: begin
          // ALU forms the target; the compare is done by the branch unit
          ctrl.alu_srca = SrcaPc;
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmB;
          case (funct3)
            3'b000:  ctrl.bj_op = BjBeq;
            3'b001:  ctrl.bj_op = BjBne;
            3'b100:  ctrl.bj_op = BjBlt;
            3'b101:  ctrl.bj_op = BjBge;
            3'b110:  ctrl.bj_op = BjBltu;
            3'b111:  ctrl.bj_op = BjBgeu;
            default: illegal = 1'b1;
          endcase
        end
        OpcLoad: begin
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmI;
          ctrl.reg_we   = 1'b1;
          ctrl.wb_sel   = WbMem;
          ctrl.mem_d_re = 1'b1;
          ctrl.mem_size = funct3;
          if (!(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) illegal = 1'b1;
        end
        OpcStore: begin
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmS;
          ctrl.mem_d_we = 1'b1;
          ctrl.mem_size = funct3;
          if (!(funct3 inside {3'b000, 3'b001, 3'b010})) illegal = 1'b1;
        end
        OpcOpImm: begin
          ctrl.alu_srcb = SrcbImm;
          ctrl.imm_sel  = ImmI;
          ctrl.reg_we   = 1'b1;
          ctrl.alu_op   = alu_base(funct3, 1'b0);
          if (funct3 == F3Sll && funct7 != F7Base) illegal = 1'b1;
          if (funct3 == F3Sr) begin
            if (funct7 == F7Alt)        ctrl.alu_op = AluSra;
            else if (funct7 != F7Base)  illegal = 1'b1;
          end
        end
        OpcOp: begin
          ctrl.reg_we = 1'b1;
          if (funct7 == F7Base) begin
            ctrl.alu_op = alu_base(funct3, 1'b0);
          end else if (funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3Sr)) begin
            ctrl.alu_op = alu_base(funct3, 1'b1);
          end else if (funct7 == F7MulDiv) begin
            if (RV32M) ctrl.alu_op = alu_muldiv(funct3);
            else       illegal = 1'b1;
          end else if (STRICT) begin
            illegal = 1'b1;
          end else begin
            // Lenient mode: only funct7[5] is significant
            ctrl.alu_op = alu_base(funct3, funct7[5]);
          end
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decode_core followed by a two-entry skid buffer so that
// in_ready is a flop and never depends combinationally on out_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          RV32M  = 1'b0,
  parameter bit          STRICT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output controlsgs_t     out_ctrl,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_illegal
);

  controlsgs_t     dec_ctrl;
  logic            dec_illegal;

  skid_state_e     state_q;
  logic            in_ready_q, out_valid_q;
  controlsgs_t     out_ctrl_q, skid_ctrl_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q;
  logic [31:0]     out_instr_q, skid_instr_q;
  logic            out_illegal_q, skid_illegal_q;

  logic            in_fire, out_fire;

  decode_core #(
    .RV32M  (RV32M),
    .STRICT (STRICT)
  ) u_core (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Skid FSM with registered handshakes; data regs load only on their fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StEmpty;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_ctrl_q     <= '0;
      out_pc_q       <= '0;
      out_instr_q    <= '0;
      out_illegal_q  <= 1'b0;
      skid_ctrl_q    <= '0;
      skid_pc_q      <= '0;
      skid_instr_q   <= '0;
      skid_illegal_q <= 1'b0;
    end else if (flush) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            out_ctrl_q    <= dec_ctrl;
            out_pc_q      <= in_pc;
            out_instr_q   <= in_instr;
            out_illegal_q <= dec_illegal;
            out_valid_q   <= 1'b1;
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          if (in_fire && out_fire) begin
            out_ctrl_q    <= dec_ctrl;
            out_pc_q      <= in_pc;
            out_instr_q   <= in_instr;
            out_illegal_q <= dec_illegal;
          end else if (in_fire) begin
            skid_ctrl_q    <= dec_ctrl;
            skid_pc_q      <= in_pc;
            skid_instr_q   <= in_instr;
            skid_illegal_q <= dec_illegal;
            in_ready_q     <= 1'b0;
            state_q        <= StFull;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            out_ctrl_q    <= skid_ctrl_q;
            out_pc_q      <= skid_pc_q;
            out_instr_q   <= skid_instr_q;
            out_illegal_q <= skid_illegal_q;
            in_ready_q    <= 1'b1;
            state_q       <= StBusy;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= StEmpty;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_pc      = out_pc_q;
  assign out_instr   = out_instr_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (RV32M off/on) share stimulus; a FIFO
// model tracks held entries and a table-driven decoder gives expected fields.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready0, out_valid0, ill0, in_ready1, out_valid1, ill1;
  controlsgs_t ctrl0, ctrl1;
  logic [31:0] pc0, instr0, pc1, instr1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  typedef struct {
    bit      ill;
    bit      reg_we;
    bit      mem_we;
    bj_op_e  bj;
    alu_op_e alu;
  } exp_t;

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                           7'h7f, 7'h0b};
  logic [6:0] f7s [4]  = '{7'h00, 7'h20, 7'h01, 7'h00};

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RV32M(1'b0), .STRICT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(ctrl0), .out_pc(pc0), .out_instr(instr0), .out_illegal(ill0)
  );

  decode_stage #(.XLEN(32), .RV32M(1'b1), .STRICT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(ctrl1), .out_pc(pc1), .out_instr(instr1), .out_illegal(ill1)
  );

  // Instruction-set level reference: legality and key fields per mnemonic
  function automatic exp_t ref_decode(input logic [31:0] w, input bit m);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [7:0] br_ok, ld_ok, st_ok;
    alu_op_e    base_tab [8];
    alu_op_e    mul_tab  [8];
    bj_op_e     bj_tab   [8];
    base_tab = '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd};
    mul_tab  = '{AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu};
    bj_tab   = '{BjBeq, BjBne, BjNoop, BjNoop, BjBlt, BjBge, BjBltu, BjBgeu};
    br_ok = 8'b1111_0011;
    ld_ok = 8'b0011_0111;
    st_ok = 8'b0000_0111;
    f3 = w[14:12];
    f7 = w[31:25];
    e.ill = 1'b1; e.reg_we = 1'b0; e.mem_we = 1'b0; e.bj = BjNoop; e.alu = AluAdd;
    if (w[1:0] != 2'b11) return e;
    case (w[6:0])
      7'h37, 7'h17: begin e.ill = 0; e.reg_we = 1; end
      7'h6f: begin e.ill = 0; e.reg_we = 1; e.bj = BjJal; end
      7'h67: begin e.ill = 0; e.reg_we = 1; e.bj = BjJalr; end
      7'h63: if (br_ok[f3]) begin e.ill = 0; e.bj = bj_tab[f3]; end
      7'h03: if (ld_ok[f3]) begin e.ill = 0; e.reg_we = 1; end
      7'h23: if (st_ok[f3]) begin e.ill = 0; e.mem_we = 1; end
      7'h13: begin
        if (!((f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})))) begin
          e.ill = 0; e.reg_we = 1;
          e.alu = (f3 == 3'd5 && f7 == 7'h20) ? AluSra : base_tab[f3];
        end
      end
      7'h33: begin
        if (f7 == 7'h00) begin
          e.ill = 0; e.alu = base_tab[f3];
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          e.ill = 0; e.alu = AluSub;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          e.ill = 0; e.alu = AluSra;
        end else if (f7 == 7'h01 && m) begin
          e.ill = 0; e.alu = mul_tab[f3];
        end
        e.reg_we = !e.ill;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          sel;
    w = $urandom;
    if ($urandom_range(0, 15) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    sel = $urandom_range(0, 4);
    if (sel < 4) w[31:25] = f7s[sel];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input bit m, input logic ir, input logic ov, input controlsgs_t c,
                           input logic [31:0] opc, input logic [31:0] oi, input logic il);
    exp_t e;
    chk(m ? "out_valid_m" : "out_valid", 64'(ov), 64'(q.size() > 0));
    chk(m ? "in_ready_m" : "in_ready", 64'(ir), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e = ref_decode(q[0].instr, m);
      chk("out_instr", 64'(oi), 64'(q[0].instr));
      chk("out_pc", 64'(opc), 64'(q[0].pc));
      chk("out_illegal", 64'(il), 64'(e.ill));
      chk("reg_we", 64'(c.reg_we), 64'(e.reg_we));
      chk("mem_d_we", 64'(c.mem_d_we), 64'(e.mem_we));
      chk("bj_op", 64'(c.bj_op), 64'(e.bj));
      chk("alu_op", 64'(c.alu_op), 64'(e.alu));
      chk("ctrl_no_x", 64'($isunknown(c)), 64'(0));
      if (e.ill) chk("illegal_ctrl_zero", 64'(c), 64'(0));
    end
  endtask

  task automatic check_both();
    check_dut(1'b0, in_ready0, out_valid0, ctrl0, pc0, instr0, ill0);
    check_dut(1'b1, in_ready1, out_valid1, ctrl1, pc1, instr1, ill1);
  endtask

  task automatic check_reset(input logic ir, input logic ov, input controlsgs_t c,
                             input logic [31:0] opc, input logic [31:0] oi, input logic il);
    chk("rst_out_valid", 64'(ov), 64'(0));
    chk("rst_in_ready", 64'(ir), 64'(1));
    chk("rst_out_ctrl", 64'(c), 64'(0));
    chk("rst_out_pc", 64'(opc), 64'(0));
    chk("rst_out_instr", 64'(oi), 64'(0));
    chk("rst_out_illegal", 64'(il), 64'(0));
  endtask

  // One clock: drive at negedge, update the FIFO model at posedge, check at next negedge
  task automatic cycle(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
    bit          inf, outf;
    logic [31:0] pc;
    pc        = $urandom & 32'hffff_fffc;
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    inf  = v && (q.size() < 2);
    outf = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back('{w, pc});
    end
    @(negedge clk);
    check_both();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    check_reset(in_ready0, out_valid0, ctrl0, pc0, instr0, ill0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI x1,x0,5 appears one cycle later
    cycle(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    chk("addi_valid", 64'(out_valid0), 64'(1));
    chk("addi_alu_op", 64'(ctrl0.alu_op), 64'(AluAdd));
    chk("addi_srcb", 64'(ctrl0.alu_srcb), 64'(SrcbImm));
    chk("addi_reg_we", 64'(ctrl0.reg_we), 64'(1));
    chk("addi_rd", 64'(instr0[11:7]), 64'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // All-zero and all-one words are illegal
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    chk("zero_illegal", 64'(ill0), 64'(1));
    chk("zero_bj_noop", 64'(ctrl0.bj_op), 64'(BjNoop));
    cycle(1'b1, 32'hffff_ffff, 1'b1, 1'b0);
    chk("ones_illegal", 64'(ill0), 64'(1));
    chk("ones_reg_we", 64'(ctrl0.reg_we), 64'(0));
    chk("ones_mem_we", 64'(ctrl0.mem_d_we), 64'(0));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // MUL x3,x1,x2 with and without M extension
    cycle(1'b1, 32'h0220_81b3, 1'b1, 1'b0);
    chk("mul_illegal_base", 64'(ill0), 64'(1));
    chk("mul_legal_m", 64'(ill1), 64'(0));
    chk("mul_alu_op", 64'(ctrl1.alu_op), 64'(AluMul));
    chk("mul_reg_we", 64'(ctrl1.reg_we), 64'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: three words, stall, then drain in order
    cycle(1'b1, 32'h0010_0113, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0193, 1'b0, 1'b0);
    chk("bp_full_in_ready", 64'(in_ready0), 64'(0));
    cycle(1'b1, 32'h0030_0213, 1'b0, 1'b0);
    chk("bp_hold_word1", 64'(instr0), 64'(32'h0010_0113));
    cycle(1'b1, 32'h0030_0213, 1'b1, 1'b0);
    chk("bp_word2", 64'(instr0), 64'(32'h0020_0193));
    cycle(1'b1, 32'h0030_0213, 1'b1, 1'b0);
    chk("bp_word3", 64'(instr0), 64'(32'h0030_0213));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, with a word offered in the same cycle
    cycle(1'b1, 32'h0010_0113, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0193, 1'b0, 1'b0);
    cycle(1'b1, 32'h0030_0213, 1'b0, 1'b1);
    chk("flush_out_valid", 64'(out_valid0), 64'(0));
    chk("flush_in_ready", 64'(in_ready0), 64'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("flush_dropped", 64'(out_valid0), 64'(0));

    // Asynchronous reset between edges while holding entries
    cycle(1'b1, 32'h0010_0113, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0193, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset(in_ready0, out_valid0, ctrl0, pc0, instr0, ill0);
    check_reset(in_ready1, out_valid1, ctrl1, pc1, instr1, ill1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h0030_0213, 1'b1, 1'b0);
    chk("post_reset_word", 64'(instr0), 64'(32'h0030_0213));

    // Random traffic against the models
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of PC fields.
REQ-002 SHALL have parameter RV32M, default 0; 1 enables M-extension decode.
REQ-003 SHALL have parameter STRICT, default 1; 1 flags reserved funct7 encodings illegal.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  in  1  synchronous discard of all held entries.
REQ-007 SHALL have port in_valid  in  1  upstream instruction valid.
REQ-008 SHALL have port in_ready  out  1  stage can accept; driven from a register.
REQ-009 SHALL have port in_instr  in  32  raw instruction word.
REQ-010 SHALL have port in_pc  in  XLEN  instruction address.
REQ-011 SHALL have port out_valid  out  1  decoded entry valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts.
REQ-013 SHALL have port out_ctrl  out  controlsgs_t  decoded control signals.
REQ-014 SHALL have port out_pc  out  XLEN  PC of the entry.
REQ-015 SHALL have port out_instr  out  32  raw word of the entry, for immediate generation and register indices.
REQ-016 SHALL have port out_illegal  out  1  entry is an illegal instruction.

Function
REQ-017 SHALL decode LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP to the established controlsgs_t encodings.
REQ-018 SHALL decode funct7=0000001 under OP to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU alu_op codes when RV32M=1; when RV32M=0 these encodings are illegal.
REQ-019 SHALL flag illegal for: in_instr[1:0]!=11; unlisted opcode; unused BRANCH/LOAD/STORE funct3; SLLI funct7!=0; SRLI/SRAI funct7 not 0000000/0100000; with STRICT=1, OP funct7 outside the legal set.
REQ-020 SHALL, for an illegal entry, drive reg_we=0, mem_d_we=0, bj_op=NOOP, and all other out_ctrl fields 0; no X on any output.
REQ-021 SHALL drive unused fields of legal entries to 0, not X.
REQ-022 SHALL use a two-entry skid buffer with state machine EMPTY, BUSY, FULL; in_fire=in_valid&in_ready; out_fire=out_valid&out_ready.
REQ-023 SHALL transition EMPTY->BUSY on in_fire; BUSY->FULL on in_fire&!out_fire; BUSY->EMPTY on out_fire&!in_fire; BUSY->BUSY on both or neither; FULL->BUSY on out_fire, with the skid entry moving to the output register.
REQ-024 SHALL set out_valid=1 in BUSY and FULL, and in_ready=0 only in FULL.
REQ-025 SHALL present an entry accepted in EMPTY on the output one cycle after in_fire.
REQ-026 SHALL preserve strict program order; no entry is dropped or duplicated without flush.
REQ-027 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-028 SHALL give flush priority over all handshakes: next state is EMPTY and any same-cycle in_fire is discarded.
REQ-029 SHALL load data registers only on the fire that writes them.

Reset
REQ-030 SHALL, on rst_n low, immediately set state EMPTY, out_valid=0, in_ready=1, out_illegal=0, and out_ctrl, out_pc, out_instr to 0.
REQ-031 SHALL discard any held entry when reset asserts mid-operation; the first accepted entry after release appears after the REQ-025 latency.

Structure
REQ-032 SHALL place controlsgs_t, opcode/funct3/funct7 constants, the new M alu_op codes and the skid state enum in the shared package.
REQ-033 SHALL instantiate one combinational sub-module, decode_core, mapping instr to {controlsgs_t, illegal}; decode_stage holds the skid buffer.

Verification
REQ-034 SHALL check: ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, alu_op ADD, alu_srcb IMM, reg_we=1, out_instr[11:7]=1.
REQ-035 SHALL check: out_ready=0, three back-to-back words -> in_ready=0 after the second; release -> words 1,2,3 emerge in order with no loss.
REQ-036 SHALL check: 0x00000000 and 0xFFFFFFFF -> out_illegal=1, reg_we=0, mem_d_we=0, bj_op NOOP.
REQ-037 SHALL check: MUL x3,x1,x2 (0x022081B3) -> RV32M=0: illegal; RV32M=1: alu_op MUL, reg_we=1.
REQ-038 SHALL check: flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming word dropped.
REQ-039 SHALL check: rst_n low mid-stream between clock edges -> outputs reach reset values before the next edge.
